uart_rx: RTL

- Oversampling 8N1 UART receiver feeding the packet-protocol stage.
- Deserialises the asynchronous rx pin into bytes and emits a one-cycle data_rdy strobe with uart_byte, the handshake the protocol parser consumes directly.
- Rejects start-bit glitches, majority-votes each bit, and flags framing errors so corrupt bytes never reach the parser.

---
 rtl/uart_pkg.sv | 19 +
 rtl/sync_ff.sv | 24 ++
 rtl/uart_rx.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receiver types and protocol constants
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } rx_state_t;

    // Framing bytes understood by the downstream packet parser.
    localparam logic [7:0] START_BYTE = 8'hFF;
    localparam logic [7:0] TRAIN_BYTE = 8'hF0;
    localparam logic [7:0] TEST_BYTE  = 8'h0F;

    localparam int DEFAULT_OVERSAMPLE = 16;

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - multi-flop synchroniser for an asynchronous single-bit input
module sync_ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling 8N1 UART receiver with glitch rejection and majority vote
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = DEFAULT_OVERSAMPLE,
    parameter int SYNC_STAGES = 2
) (
    input  logic       uart_sampling_clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] uart_byte,
    output logic       data_rdy,
    output logic       framing_err,
    output logic       busy
);

    localparam int M  = OVERSAMPLE / 2;
    localparam int TW = $clog2(OVERSAMPLE);

    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_VA   = TW'(M - 1);
    localparam logic [TW-1:0] TICK_VB   = TW'(M);
    localparam logic [TW-1:0] TICK_VC   = TW'(M + 1);

    logic            rx_s;
    rx_state_t       state_q;
    logic [TW-1:0]   tick_q;
    logic [TW-1:0]   tick_d;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shreg_q;
    logic            s_a_q;
    logic            s_b_q;
    logic            vote;
    logic [7:0]      uart_byte_q;
    logic            data_rdy_q;
    logic            framing_err_q;
    logic            busy_q;

    sync_ff #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk_i (uart_sampling_clk),
        .rst_i (rst),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    // Third vote sample is the live rx_s at tick M+1.
    assign vote = (s_a_q & s_b_q) | (s_a_q & rx_s) | (s_b_q & rx_s);

    always_comb begin
        tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
    end

    always_ff @(posedge uart_sampling_clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            tick_q        <= '0;
            bit_idx_q     <= 3'd0;
            shreg_q       <= 8'h00;
            s_a_q         <= 1'b1;
            s_b_q         <= 1'b1;
            uart_byte_q   <= 8'h00;
            data_rdy_q    <= 1'b0;
            framing_err_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            data_rdy_q    <= 1'b0;
            framing_err_q <= 1'b0;

            if (tick_q == TICK_VA) s_a_q <= rx_s;
            if (tick_q == TICK_VB) s_b_q <= rx_s;

            case (state_q)
                S_IDLE: begin
                    tick_q    <= '0;
                    bit_idx_q <= 3'd0;
                    busy_q    <= 1'b0;
                    if (!rx_s) begin
                        state_q <= S_START;
                        busy_q  <= 1'b1;
                    end
                end

                S_START: begin
                    tick_q <= tick_d;
                    if (tick_q == TICK_VC && vote) begin
                        state_q <= S_IDLE;
                        tick_q  <= '0;
                        busy_q  <= 1'b0;
                    end else if (tick_q == TICK_LAST) begin
                        state_q   <= S_DATA;
                        bit_idx_q <= 3'd0;
                    end
                end

                S_DATA: begin
                    tick_q <= tick_d;
                    if (tick_q == TICK_VC) begin
                        shreg_q <= {vote, shreg_q[7:1]};
                    end
                    if (tick_q == TICK_LAST) begin
                        if (bit_idx_q == 3'd7) begin
                            state_q <= S_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end

                // Leave at the stop-bit mid-sample so a following start edge is not missed.
                S_STOP: begin
                    tick_q <= tick_d;
                    if (tick_q == TICK_VC) begin
                        tick_q <= '0;
                        if (vote) begin
                            uart_byte_q <= shreg_q;
                            data_rdy_q  <= 1'b1;
                            state_q     <= S_IDLE;
                            busy_q      <= 1'b0;
                        end else begin
                            framing_err_q <= 1'b1;
                            state_q       <= S_BREAK;
                        end
                    end
                end

                S_BREAK: begin
                    tick_q <= '0;
                    if (rx_s) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    tick_q  <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign uart_byte   = uart_byte_q;
    assign data_rdy    = data_rdy_q;
    assign framing_err = framing_err_q;
    assign busy        = busy_q;

endmodule
